// File: rtl/fifo_1r1w_pkg.sv
// rtl/fifo_1r1w_pkg.sv - default sizing shared by the fifo_1r1w slice
package fifo_1r1w_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_DEPTH  = 32;

endpackage

// File: rtl/fifo_1r1w_ram_sdp.sv
// rtl/fifo_1r1w_ram_sdp.sv - simple dual-port RAM, one write port, one registered read port
module ram_sdp_1r1w #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 32,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Unreset storage and read register; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_1r1w.sv
// rtl/fifo_1r1w.sv - synchronous FIFO with registered read data; FIFO_1R1W_COUNT_EN adds an occupancy counter
module fifo_1r1w
  import fifo_1r1w_pkg::*;
#(
  parameter  int DWIDTH = DEF_DWIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AWIDTH = $clog2(DEPTH),
  localparam int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  output logic              o_full,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_pop,
  output logic              o_empty,
  output logic              o_rvalid,
  output logic [DWIDTH-1:0] o_rdata,
  output logic [CWIDTH-1:0] o_count
);

  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  logic [AWIDTH-1:0] push_idx;
  logic [AWIDTH-1:0] pop_idx;
  logic              push_par;
  logic              pop_par;
  logic              rvalid_q;
  logic              rd_seen;
  logic [DWIDTH-1:0] ram_rdata;

  ram_sdp_1r1w #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (i_push),
    .wr_addr (push_idx),
    .wr_data (i_wdata),
    .rd_en   (i_pop),
    .rd_addr (pop_idx),
    .rd_data (ram_rdata)
  );

  // Write pointer with wrap parity; wraps at DEPTH-1 so any depth works.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      push_idx <= '0;
      push_par <= 1'b0;
    end else if (i_push) begin
      if (push_idx == LAST_IDX) begin
        push_idx <= '0;
        push_par <= ~push_par;
      end else begin
        push_idx <= push_idx + AWIDTH'(1);
      end
    end
  end

  // Read pointer with wrap parity, mirroring the write side.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pop_idx <= '0;
      pop_par <= 1'b0;
    end else if (i_pop) begin
      if (pop_idx == LAST_IDX) begin
        pop_idx <= '0;
        pop_par <= ~pop_par;
      end else begin
        pop_idx <= pop_idx + AWIDTH'(1);
      end
    end
  end

  // Read-valid strobe, plus a sticky flag that gates the unreset RAM output to zero until the first pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      rvalid_q <= i_pop;
      rd_seen  <= rd_seen | i_pop;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rd_seen ? ram_rdata : '0;
  assign o_empty  = (push_idx == pop_idx) && (push_par == pop_par);
  assign o_full   = (push_idx == pop_idx) && (push_par != pop_par);

`ifdef FIFO_1R1W_COUNT_EN
  logic [CWIDTH-1:0] count_q;

  // Occupancy: up on push only, down on pop only, unchanged otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (i_push && !i_pop) begin
      count_q <= count_q + CWIDTH'(1);
    end else if (i_pop && !i_push) begin
      count_q <= count_q - CWIDTH'(1);
    end
  end

  assign o_count = count_q;
`else
  assign o_count = '0;
`endif

endmodule
